// File: rtl/acs_path_metric_unit_if.sv
// Symbol-in / decision-out bundle of the Viterbi add-compare-select stage.
// The slave modport is the ACS unit; the master modport is its environment.
interface acs_path_metric_unit_if #(
   parameter int PM_W = 6
);
   logic [1:0]      symbol;
   logic            sym_valid;
   logic            sym_sof;
   logic            sym_eof;
   logic            sym_ready;
   logic [3:0]      decision;
   logic [1:0]      best_state;
   logic [PM_W-1:0] best_pm;
   logic [15:0]     sym_cnt;
   logic            out_eof;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output symbol, sym_valid, sym_sof, sym_eof, out_ready,
      input  sym_ready, decision, best_state, best_pm, sym_cnt, out_eof, out_valid
   );

   modport slave (
      input  symbol, sym_valid, sym_sof, sym_eof, out_ready,
      output sym_ready, decision, best_state, best_pm, sym_cnt, out_eof, out_valid
   );
endinterface

// File: rtl/acs_path_metric_unit.sv
// Add-compare-select stage for the rate-1/2, K=3 (7,5) Viterbi decoder:
// four registered path metrics with normalisation and one survivor vector per symbol.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | between frames; symbols without sof are accepted and dropped
// ST_RUN   | inside a frame; every accepted symbol runs one ACS step
module acs_path_metric_unit #(
   parameter int PM_W    = 6,
   parameter int INIT_PM = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   acs_path_metric_unit_if.slave  bus
);
   localparam int CW = PM_W + 1;
   localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]      state_q;
   logic [PM_W-1:0] pm_q      [4];
   logic [PM_W-1:0] pm_base   [4];
   logic [CW-1:0]   cand_a    [4];
   logic [CW-1:0]   cand_b    [4];
   logic [CW-1:0]   pm_new    [4];
   logic [PM_W-1:0] pm_next   [4];
   logic [3:0]      dec_new;
   logic [1:0]      best_idx;
   logic [CW-1:0]   best_val;
   logic            norm;

   logic            out_valid_q;
   logic [3:0]      decision_q;
   logic [1:0]      best_state_q;
   logic [PM_W-1:0] best_pm_q;
   logic [15:0]     sym_cnt_q;
   logic            out_eof_q;

   logic            ready;
   logic            accept;
   logic            fire;

   // Hamming distance between the received pair and the code emitted when
   // input u leaves state p={s1,s0}: c0 = u^s1^s0 (G0=7), c1 = u^s0 (G1=5).
   function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic u,
                                                input logic [1:0] sym);
      logic [1:0] diff;
      diff = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   assign ready  = ~out_valid_q | bus.out_ready;
   assign accept = bus.sym_valid & ready;
   assign fire   = accept & ((state_q == ST_RUN) | bus.sym_sof);

   always_comb begin
      for (int s = 0; s < 4; s++) begin
         if (bus.sym_sof)
            pm_base[s] = (s == 0) ? '0 : INIT_V;
         else
            pm_base[s] = pm_q[s];
      end

      // Next state n={u,x} is reached from {x,0} (A) or {x,1} (B); ties keep A.
      for (int n = 0; n < 4; n++) begin
         cand_a[n]  = {1'b0, pm_base[{n[0], 1'b0}]}
                    + CW'(branch_metric({n[0], 1'b0}, n[1], bus.symbol));
         cand_b[n]  = {1'b0, pm_base[{n[0], 1'b1}]}
                    + CW'(branch_metric({n[0], 1'b1}, n[1], bus.symbol));
         dec_new[n] = cand_b[n] < cand_a[n];
         pm_new[n]  = dec_new[n] ? cand_b[n] : cand_a[n];
      end

      best_idx = 2'd0;
      best_val = pm_new[0];
      for (int n = 1; n < 4; n++) begin
         if (pm_new[n] < best_val) begin
            best_idx = 2'(n);
            best_val = pm_new[n];
         end
      end

      // Subtracting half-range from every metric keeps all differences intact.
      norm = pm_new[0][PM_W-1] & pm_new[1][PM_W-1] & pm_new[2][PM_W-1] & pm_new[3][PM_W-1];
      for (int n = 0; n < 4; n++) begin
         pm_next[n] = pm_new[n][PM_W-1:0];
         if (norm)
            pm_next[n][PM_W-1] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pm_q[0]      <= '0;
         pm_q[1]      <= INIT_V;
         pm_q[2]      <= INIT_V;
         pm_q[3]      <= INIT_V;
         out_valid_q  <= 1'b0;
         decision_q   <= '0;
         best_state_q <= '0;
         best_pm_q    <= '0;
         sym_cnt_q    <= '0;
         out_eof_q    <= 1'b0;
      end else begin
         if (fire) begin
            for (int n = 0; n < 4; n++)
               pm_q[n] <= pm_next[n];
            out_valid_q  <= 1'b1;
            decision_q   <= dec_new;
            best_state_q <= best_idx;
            best_pm_q    <= best_val[PM_W-1:0];
            out_eof_q    <= bus.sym_eof;
            if (bus.sym_sof)
               sym_cnt_q <= '0;
            else if (sym_cnt_q != 16'hFFFF)
               sym_cnt_q <= sym_cnt_q + 16'd1;
            state_q <= bus.sym_eof ? ST_IDLE : ST_RUN;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.sym_ready  = ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.decision   = decision_q;
   assign bus.best_state = best_state_q;
   assign bus.best_pm    = best_pm_q;
   assign bus.sym_cnt    = sym_cnt_q;
   assign bus.out_eof    = out_eof_q;
endmodule
